// File: rtl/key_debounce_pkg.sv
// Shared types and constants for the key debouncer array.
// Pure declarations: no logic, no latency, no backpressure.
package key_debounce_pkg;

  typedef enum logic [1:0] {KD_IDLE, KD_PRESSED, KD_HELD} kd_state_t;

  localparam int KD_SYNC_STAGES = 2;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: synchroniser, press/hold/release FSM and counters.
// Events registered KD_SYNC_STAGES + DEBOUNCE_MS cycles after a stable level change; no backpressure.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000
) (
  input  logic clk_1kHz,
  input  logic rst_n,
  input  logic i_key,
  output logic o_state,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam int              HOLD_W    = $clog2(LONG_MS + 1);
  localparam logic [7:0]      DEB_LAST  = 8'(DEBOUNCE_MS - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_MS - 1);

  logic [KD_SYNC_STAGES-1:0] r_sync;
  kd_state_t                 r_state;
  logic [7:0]                r_deb_cnt;
  logic [HOLD_W-1:0]         r_hold_cnt;
  logic                      w_k;
  logic                      w_deb_done;

  assign w_k        = r_sync[KD_SYNC_STAGES-1];
  assign w_deb_done = (r_deb_cnt == DEB_LAST);

  // i_key is already polarity-normalised, so reset loads 0 (released)
  always_ff @(posedge clk_1kHz or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[KD_SYNC_STAGES-2:0], i_key};
    end
  end

  always_ff @(posedge clk_1kHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= KD_IDLE;
      r_deb_cnt  <= '0;
      r_hold_cnt <= '0;
      o_state    <= 1'b0;
      o_press    <= 1'b0;
      o_release  <= 1'b0;
      o_long     <= 1'b0;
    end else begin
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_long    <= 1'b0;
      case (r_state)
        KD_IDLE: begin
          if (!w_k) begin
            r_deb_cnt <= '0;
          end else if (w_deb_done) begin
            r_state    <= KD_PRESSED;
            r_deb_cnt  <= '0;
            r_hold_cnt <= '0;
            o_press    <= 1'b1;
            o_state    <= 1'b1;
          end else if (r_deb_cnt != 8'hFF) begin
            r_deb_cnt <= r_deb_cnt + 8'd1;
          end
        end
        KD_PRESSED, KD_HELD: begin
          // Release acceptance takes priority over the long threshold
          if (!w_k && w_deb_done) begin
            r_state    <= KD_IDLE;
            r_deb_cnt  <= '0;
            r_hold_cnt <= '0;
            o_release  <= 1'b1;
            o_state    <= 1'b0;
          end else begin
            if (w_k) begin
              r_deb_cnt <= '0;
            end else if (r_deb_cnt != 8'hFF) begin
              r_deb_cnt <= r_deb_cnt + 8'd1;
            end
            // Hold timer runs through release bounces; frozen once HELD
            if (r_state == KD_PRESSED) begin
              if (r_hold_cnt == LONG_LAST) begin
                r_state <= KD_HELD;
                o_long  <= 1'b1;
              end
              if (r_hold_cnt != '1) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
              end
            end
          end
        end
        default: begin
          r_state <= KD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_debounce_array.sv
// N independent debounced keys with press/release/long events and a registered any-pressed flag.
// Events KD_SYNC_STAGES + DEBOUNCE_MS cycles after a stable pin change, key_any one cycle later; no backpressure.
module key_debounce_array
  import key_debounce_pkg::*;
#(
  parameter int N_KEYS      = 4,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic              clk_1kHz,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_pulse,
  output logic              key_any
);

  initial begin
    if (LONG_MS <= DEBOUNCE_MS) $fatal(1, "key_debounce_array: LONG_MS must exceed DEBOUNCE_MS");
    if (N_KEYS < 1)             $fatal(1, "key_debounce_array: N_KEYS must be at least 1");
  end

  logic [N_KEYS-1:0] w_key_norm;
  logic              r_key_any;

  // Normalise so that 1 always means pressed downstream
  assign w_key_norm = (ACTIVE_LOW != 0) ? ~key_in : key_in;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_MS(DEBOUNCE_MS),
      .LONG_MS    (LONG_MS)
    ) u_ch (
      .clk_1kHz (clk_1kHz),
      .rst_n    (rst_n),
      .i_key    (w_key_norm[g]),
      .o_state  (key_state[g]),
      .o_press  (press_pulse[g]),
      .o_release(release_pulse[g]),
      .o_long   (long_pulse[g])
    );
  end

  always_ff @(posedge clk_1kHz or negedge rst_n) begin
    if (!rst_n) begin
      r_key_any <= 1'b0;
    end else begin
      r_key_any <= |key_state;
    end
  end

  assign key_any = r_key_any;

endmodule

// File: tb/tb_key_debounce_array.sv
// Bench for key_debounce_array: three instances (default, active-high, DEBOUNCE_MS=1/LONG_MS=5)
// checked every cycle against a window-based event model plus directed timing checks.
`timescale 1ns/1ps
module tb_key_debounce_array;

  logic       clk_1kHz = 1'b0;
  logic       rst_n    = 1'b1;
  logic [3:0] kin [3];
  logic [3:0] st [3];
  logic [3:0] pp [3];
  logic [3:0] rp [3];
  logic [3:0] lp [3];
  logic       any [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_1kHz = ~clk_1kHz;

  key_debounce_array #(.N_KEYS(4), .DEBOUNCE_MS(20), .LONG_MS(1000), .ACTIVE_LOW(1)) u_dut0 (
    .clk_1kHz(clk_1kHz), .rst_n(rst_n), .key_in(kin[0]), .key_state(st[0]),
    .press_pulse(pp[0]), .release_pulse(rp[0]), .long_pulse(lp[0]), .key_any(any[0]));
  key_debounce_array #(.N_KEYS(4), .DEBOUNCE_MS(20), .LONG_MS(1000), .ACTIVE_LOW(0)) u_dut1 (
    .clk_1kHz(clk_1kHz), .rst_n(rst_n), .key_in(kin[1]), .key_state(st[1]),
    .press_pulse(pp[1]), .release_pulse(rp[1]), .long_pulse(lp[1]), .key_any(any[1]));
  key_debounce_array #(.N_KEYS(4), .DEBOUNCE_MS(1), .LONG_MS(5), .ACTIVE_LOW(1)) u_dut2 (
    .clk_1kHz(clk_1kHz), .rst_n(rst_n), .key_in(kin[2]), .key_state(st[2]),
    .press_pulse(pp[2]), .release_pulse(rp[2]), .long_pulse(lp[2]), .key_any(any[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_1kHz);
    #1;
  endtask

  // Reference model: a level change is accepted once the last DEB samples seen
  // after the two-stage pipeline all show the opposite level.
  int         deb_p  [3] = '{20, 20, 1};
  int         long_p [3] = '{1000, 1000, 5};
  bit         al_p   [3] = '{1'b1, 1'b0, 1'b1};
  bit [3:0]   p0 [3];
  bit [3:0]   p1 [3];
  bit [31:0]  hist [3][4];
  bit         lvl [3][4];
  int         press_t [3][4];
  bit [3:0]   e_st [3];
  bit [3:0]   e_pp [3];
  bit [3:0]   e_rp [3];
  bit [3:0]   e_lp [3];
  bit         e_any [3];
  int         cyc = 0;
  bit [3:0]   m_k;
  bit [31:0]  m_msk;
  bit [31:0]  m_win;

  always @(posedge clk_1kHz or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0;
      for (int d = 0; d < 3; d++) begin
        p0[d] = '0; p1[d] = '0;
        e_st[d] = '0; e_pp[d] = '0; e_rp[d] = '0; e_lp[d] = '0; e_any[d] = 1'b0;
        for (int c = 0; c < 4; c++) begin
          hist[d][c] = '0; lvl[d][c] = 1'b0; press_t[d][c] = 0;
        end
      end
    end else begin
      cyc++;
      for (int d = 0; d < 3; d++) begin
        e_any[d] = |e_st[d];
        e_pp[d] = '0; e_rp[d] = '0; e_lp[d] = '0;
        m_k   = p1[d];
        p1[d] = p0[d];
        p0[d] = al_p[d] ? ~kin[d] : kin[d];
        m_msk = 32'hFFFF_FFFF >> (32 - deb_p[d]);
        for (int c = 0; c < 4; c++) begin
          hist[d][c] = {hist[d][c][30:0], m_k[c]};
          m_win = hist[d][c] & m_msk;
          if (lvl[d][c] ? (m_win == 32'd0) : (m_win == m_msk)) begin
            lvl[d][c] = !lvl[d][c];
            if (lvl[d][c]) begin
              e_pp[d][c] = 1'b1;
              press_t[d][c] = cyc;
            end else begin
              e_rp[d][c] = 1'b1;
            end
          end else if (lvl[d][c] && cyc == press_t[d][c] + long_p[d]) begin
            e_lp[d][c] = 1'b1;
          end
          e_st[d][c] = lvl[d][c];
        end
      end
    end
  end

  always @(negedge clk_1kHz) begin
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d key_state", d), st[d], e_st[d]);
      chk($sformatf("d%0d press", d), pp[d], e_pp[d]);
      chk($sformatf("d%0d release", d), rp[d], e_rp[d]);
      chk($sformatf("d%0d long", d), lp[d], e_lp[d]);
      chk($sformatf("d%0d key_any", d), any[d], e_any[d]);
    end
  end

  initial begin
    kin[0] = 4'hF; kin[1] = 4'h0; kin[2] = 4'hF;
    #1 rst_n = 1'b0;
    tick(3);
    chk("rst state", st[0], 0);
    chk("rst pulses", pp[0] | rp[0] | lp[0], 0);
    chk("rst any", any[0], 0);
    rst_n = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick(1);
      chk("idle quiet", pp[0] | rp[0] | lp[0], 0);
    end

    // Clean press and release on key 0
    kin[0][0] = 1'b0;
    for (int i = 1; i <= 22; i++) begin
      tick(1);
      chk("clean press", pp[0][0], i == 22);
    end
    chk("clean state", st[0][0], 1);
    tick(5);
    kin[0][0] = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      tick(1);
      chk("clean release", rp[0][0], i == 22);
    end

    // Bounce on key 1: 19 low, 1 high, then low
    kin[0][1] = 1'b0;
    for (int i = 1; i <= 19; i++) begin
      tick(1);
      chk("bounce quiet", pp[0][1], 0);
    end
    kin[0][1] = 1'b1;
    tick(1);
    kin[0][1] = 1'b0;
    for (int i = 1; i <= 22; i++) begin
      tick(1);
      chk("bounce press", pp[0][1], i == 22);
    end
    kin[0][1] = 1'b1;
    tick(30);

    // Long press on key 2
    kin[0][2] = 1'b0;
    for (int i = 1; i <= 1100; i++) begin
      tick(1);
      chk("long press", pp[0][2], i == 22);
      chk("long pulse", lp[0][2], i == 1022);
    end
    kin[0][2] = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      tick(1);
      chk("long release", rp[0][2], i == 22);
    end
    tick(10);

    // All keys together; key 3 release lands on the long threshold cycle
    kin[0] = 4'h0;
    for (int i = 1; i <= 1030; i++) begin
      tick(1);
      chk("simul press", pp[0], (i == 22) ? 4'hF : 4'h0);
      chk("simul any", any[0], i >= 23);
      chk("tie long", lp[0], (i == 1022) ? 4'h7 : 4'h0);
      chk("tie release", rp[0][3], i == 1022);
      if (i == 1000) kin[0][3] = 1'b1;
    end
    kin[0] = 4'hF;
    tick(30);

    // Reset in the middle of a hold
    kin[0][0] = 1'b0;
    tick(500);
    rst_n = 1'b0;
    #1;
    chk("midrst state", st[0], 0);
    chk("midrst any", any[0], 0);
    tick(3);
    rst_n = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      tick(1);
      chk("post-rst press", pp[0][0], i == 22);
    end
    kin[0][0] = 1'b1;
    tick(30);

    // Active-high instance
    kin[1][0] = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      tick(1);
      chk("pol press", pp[1][0], i == 22);
      chk("pol state", st[1][0], i >= 22);
    end
    kin[1][0] = 1'b0;
    tick(30);

    // Random toggling on all instances, checked by the model
    for (int n = 0; n < 4000; n++) begin
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 30) == 0) kin[0][c] = ~kin[0][c];
        if ($urandom_range(0, 30) == 0) kin[1][c] = ~kin[1][c];
        if ($urandom_range(0, 3) == 0)  kin[2][c] = ~kin[2][c];
      end
      tick(1);
    end
    kin[0] = 4'hF; kin[1] = 4'h0; kin[2] = 4'hF;
    tick(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
